// File: rtl/ariane_irq_conditioner.sv
// ariane_irq_conditioner: conditions raw interrupt lines from the block-design IP
// before they reach the peripherals wrapper irqs_in bus.
// Per source: optional polarity inversion, SYNC_STAGES-deep synchroniser,
// FILTER_CYCLES glitch filter, then either level pass-through or rising-edge to
// PULSE_CYCLES-wide pulse conversion with per-source enable.
// Ports:
//   aclk          clock
//   aresetn       asynchronous active-low reset
//   irqs_raw_i    raw interrupt lines, asynchronous to aclk
//   irq_enable_i  per-source enable, synchronous to aclk
//   irqs_out      conditioned active-high interrupts (registered)
//   edge_lost_o   one-cycle pulse when an edge source retriggers mid-pulse
module ariane_irq_conditioner #(
    parameter int unsigned                   NUMBER_INTERRUPTS = 4,
    parameter int unsigned                   SYNC_STAGES       = 2,
    parameter int unsigned                   FILTER_CYCLES     = 4,
    parameter int unsigned                   PULSE_CYCLES      = 8,
    parameter logic [NUMBER_INTERRUPTS-1:0]  EDGE_MASK         = '0,
    parameter logic [NUMBER_INTERRUPTS-1:0]  INVERT_MASK       = '0
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [NUMBER_INTERRUPTS-1:0] irqs_raw_i,
    input  logic [NUMBER_INTERRUPTS-1:0] irq_enable_i,
    output logic [NUMBER_INTERRUPTS-1:0] irqs_out,
    output logic [NUMBER_INTERRUPTS-1:0] edge_lost_o
);

    localparam int unsigned CNT_W  = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam int unsigned PCNT_W = $clog2(PULSE_CYCLES + 1);

    localparam logic [CNT_W-1:0]  FILT_LAST  = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [PCNT_W-1:0] PULSE_LOAD = PCNT_W'(PULSE_CYCLES);

    for (genvar gi = 0; gi < NUMBER_INTERRUPTS; gi++) begin : g_src
        logic                   a_inv;
        logic                   s_sync;
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   f_q, f_d;
        logic [CNT_W-1:0]       c_q, c_d;
        logic                   out_q, out_d;

        // Single inversion gate ahead of the first sync flop
        assign a_inv  = irqs_raw_i[gi] ^ INVERT_MASK[gi];
        assign s_sync = sync_q[SYNC_STAGES-1];

        // Synchroniser chain
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], a_inv};
            end
        end

        // Glitch filter: a change must hold FILTER_CYCLES consecutive cycles
        always_comb begin
            f_d = f_q;
            c_d = '0;
            if (s_sync != f_q) begin
                if (c_q == FILT_LAST) begin
                    f_d = s_sync;
                end else begin
                    c_d = c_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                f_q <= 1'b0;
                c_q <= '0;
            end else begin
                f_q <= f_d;
                c_q <= c_d;
            end
        end

        assign irqs_out[gi] = out_q;

        if (EDGE_MASK[gi]) begin : g_edge
            logic              rise_d, rise_q;
            logic [PCNT_W-1:0] p_q, p_d;
            logic              lost_q, lost_d;

            // Registered rise keeps edge-mode latency equal to level mode
            assign rise_d = f_d & ~f_q;

            // Pulse counter: reload on rise, retrigger reports lost edge
            always_comb begin
                p_d    = p_q;
                lost_d = 1'b0;
                if (!irq_enable_i[gi]) begin
                    p_d = '0;
                end else if (rise_q) begin
                    p_d    = PULSE_LOAD;
                    lost_d = (p_q != '0);
                end else if (p_q != '0) begin
                    p_d = p_q - PCNT_W'(1);
                end
                out_d = (p_d != '0) & irq_enable_i[gi];
            end

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    rise_q <= 1'b0;
                    p_q    <= '0;
                    lost_q <= 1'b0;
                    out_q  <= 1'b0;
                end else begin
                    rise_q <= rise_d;
                    p_q    <= p_d;
                    lost_q <= lost_d;
                    out_q  <= out_d;
                end
            end

            assign edge_lost_o[gi] = lost_q;
        end else begin : g_level
            assign out_d = f_q & irq_enable_i[gi];

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    out_q <= 1'b0;
                end else begin
                    out_q <= out_d;
                end
            end

            assign edge_lost_o[gi] = 1'b0;
        end
    end

endmodule

// File: tb/tb_ariane_irq_conditioner.sv
// Testbench for ariane_irq_conditioner: directed scenarios plus randomized raw/enable
// traffic, checked every cycle against a timeline-based reference model.
module tb_ariane_irq_conditioner;

    localparam int unsigned NI    = 4;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned FILT  = 4;
    localparam int unsigned PULSE = 8;
    localparam logic [NI-1:0] EDGE = 4'b0010;
    localparam logic [NI-1:0] INV  = 4'b0100;

    logic          aclk;
    logic          aresetn;
    logic [NI-1:0] irqs_raw_i;
    logic [NI-1:0] irq_enable_i;
    logic [NI-1:0] irqs_out;
    logic [NI-1:0] edge_lost_o;

    ariane_irq_conditioner #(
        .NUMBER_INTERRUPTS (NI),
        .SYNC_STAGES       (SYNC),
        .FILTER_CYCLES     (FILT),
        .PULSE_CYCLES      (PULSE),
        .EDGE_MASK         (EDGE),
        .INVERT_MASK       (INV)
    ) u_dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .irqs_raw_i   (irqs_raw_i),
        .irq_enable_i (irq_enable_i),
        .irqs_out     (irqs_out),
        .edge_lost_o  (edge_lost_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: sample history, filtered value, pending rise, pulse end edge
    int            m_edge;
    logic [15:0]   hist [NI];
    bit            f_m [NI];
    bit            rise_m [NI];
    int            end_m [NI];
    logic [NI-1:0] exp_out;
    logic [NI-1:0] exp_lost;

    // Observations of the DUT, compared against constants in directed tests
    logic [NI-1:0] prev_obs;
    int            rise_edge [NI];
    int            fall_edge [NI];
    int            high_cnt [NI];
    int            lost_cnt [NI];

    logic [NI-1:0] raw_v;
    logic [NI-1:0] en_v;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, act, exp, m_edge, $time);
        end
    endtask

    task automatic model_reset();
        m_edge   = 0;
        exp_out  = '0;
        exp_lost = '0;
        for (int i = 0; i < int'(NI); i++) begin
            hist[i]   = '0;
            f_m[i]    = 1'b0;
            rise_m[i] = 1'b0;
            end_m[i]  = 0;
        end
    endtask

    task automatic obs_reset();
        prev_obs = '0;
        for (int i = 0; i < int'(NI); i++) begin
            rise_edge[i] = -1;
            fall_edge[i] = -1;
            high_cnt[i]  = 0;
            lost_cnt[i]  = 0;
        end
    endtask

    // One aclk edge of the reference model for the inputs sampled at that edge
    task automatic model_step(input logic [NI-1:0] raw, input logic [NI-1:0] en);
        logic [NI-1:0] nout;
        logic [NI-1:0] nlost;
        bit            flip;
        bit            fo;
        m_edge++;
        for (int i = 0; i < int'(NI); i++) begin
            hist[i] = {hist[i][14:0], raw[i] ^ INV[i]};
            fo   = f_m[i];
            // Filtered value flips once the last FILT synchronised samples all differ
            flip = 1'b1;
            for (int k = int'(SYNC); k < int'(SYNC + FILT); k++) begin
                if (hist[i][k] == fo) flip = 1'b0;
            end
            nlost[i] = 1'b0;
            if (EDGE[i]) begin
                if (!en[i]) begin
                    end_m[i] = 0;
                    nout[i]  = 1'b0;
                end else if (rise_m[i]) begin
                    nlost[i] = exp_out[i];
                    end_m[i] = m_edge + int'(PULSE) - 1;
                    nout[i]  = 1'b1;
                end else begin
                    nout[i] = (m_edge <= end_m[i]);
                end
            end else begin
                nout[i] = fo & en[i];
            end
            rise_m[i] = flip & ~fo;
            if (flip) f_m[i] = ~fo;
        end
        exp_out  = nout;
        exp_lost = nlost;
    endtask

    // Drive at a falling edge, advance one cycle, compare at the next falling edge
    task automatic step();
        irqs_raw_i   = raw_v;
        irq_enable_i = en_v;
        model_step(raw_v, en_v);
        @(negedge aclk);
        check_eq("irqs_out", 32'(irqs_out), 32'(exp_out));
        check_eq("edge_lost", 32'(edge_lost_o), 32'(exp_lost));
        for (int i = 0; i < int'(NI); i++) begin
            if (irqs_out[i] && !prev_obs[i]) rise_edge[i] = m_edge;
            if (!irqs_out[i] && prev_obs[i]) fall_edge[i] = m_edge;
            if (irqs_out[i]) high_cnt[i]++;
            if (edge_lost_o[i]) lost_cnt[i]++;
        end
        prev_obs = irqs_out;
    endtask

    task automatic run_until(input int target);
        while (m_edge < target) step();
    endtask

    // Asynchronous reset mid-cycle; release lands on a falling edge
    task automatic do_reset();
        #2 aresetn = 1'b0;
        #1;
        check_eq("rst_irqs_out", 32'(irqs_out), 32'(0));
        check_eq("rst_edge_lost", 32'(edge_lost_o), 32'(0));
        model_reset();
        obs_reset();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        aresetn      = 1'b0;
        raw_v        = 4'b0100;
        en_v         = 4'b1011;
        irqs_raw_i   = raw_v;
        irq_enable_i = en_v;
        model_reset();
        obs_reset();
        repeat (2) @(negedge aclk);
        check_eq("reset_irqs_out", 32'(irqs_out), 32'(0));
        check_eq("reset_edge_lost", 32'(edge_lost_o), 32'(0));
        aresetn = 1'b1;

        // Level source 0; source 2 inverted, activated while disabled
        run_until(10);
        raw_v[0] = 1'b1;
        raw_v[2] = 1'b0;
        run_until(40);
        raw_v[0] = 1'b0;
        run_until(55);
        check_eq("src2_disabled_high", 32'(high_cnt[2]), 32'(0));
        en_v[2] = 1'b1;
        run_until(60);
        check_eq("lvl_rise_edge", 32'(rise_edge[0]), 32'(17));
        check_eq("lvl_fall_edge", 32'(fall_edge[0]), 32'(47));
        check_eq("enable_rise_edge", 32'(rise_edge[2]), 32'(56));

        // Edge source 1 held high; glitch then valid pulse on level source 3
        high_cnt[1] = 0;
        lost_cnt[1] = 0;
        raw_v[1] = 1'b1;
        raw_v[3] = 1'b1;
        run_until(63);
        raw_v[3] = 1'b0;
        run_until(100);
        check_eq("glitch_high", 32'(high_cnt[3]), 32'(0));
        raw_v[3] = 1'b1;
        run_until(104);
        raw_v[3] = 1'b0;
        run_until(120);
        check_eq("filt4_high", 32'(high_cnt[3]), 32'(4));
        check_eq("filt4_rise_edge", 32'(rise_edge[3]), 32'(107));
        check_eq("filt4_fall_edge", 32'(fall_edge[3]), 32'(111));
        run_until(160);
        raw_v[1] = 1'b0;
        check_eq("pulse_rise_edge", 32'(rise_edge[1]), 32'(67));
        check_eq("pulse_width", 32'(high_cnt[1]), 32'(8));
        check_eq("pulse_no_lost", 32'(lost_cnt[1]), 32'(0));

        // Second filtered rise lands on the last pulse cycle: extended, no gap
        run_until(170);
        high_cnt[1] = 0;
        lost_cnt[1] = 0;
        raw_v[1] = 1'b1;
        run_until(174);
        raw_v[1] = 1'b0;
        run_until(178);
        raw_v[1] = 1'b1;
        run_until(200);
        check_eq("retrig_rise_edge", 32'(rise_edge[1]), 32'(177));
        check_eq("retrig_width", 32'(high_cnt[1]), 32'(16));
        check_eq("retrig_lost", 32'(lost_cnt[1]), 32'(1));

        // Reset in the middle of a pulse, raw still high afterwards
        raw_v[1] = 1'b0;
        run_until(215);
        raw_v[1] = 1'b1;
        run_until(225);
        check_eq("pre_rst_rise_edge", 32'(rise_edge[1]), 32'(222));
        check_eq("pre_rst_high", 32'(irqs_out[1]), 32'(1));
        do_reset();
        run_until(12);
        check_eq("post_rst_rise_edge", 32'(rise_edge[1]), 32'(7));

        // Randomized traffic with one reset in the middle
        for (int it = 0; it < 3000; it++) begin
            for (int b = 0; b < int'(NI); b++) begin
                if ($urandom_range(5) == 0) raw_v[b] = ~raw_v[b];
                if ($urandom_range(63) == 0) en_v[b] = ~en_v[b];
            end
            if (it == 1500) do_reset();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
